// File: rtl/sipmroc_serial_rx.sv
`timescale 1ns/1ps
// SiPMROC serial frame receiver: rebuilds 32-bit event frames from the
// serial_data_en/serial_data link and checks header, parity, channel and
// length. Good frames go out as a valid/ready stream. Errors are counted
// and latched into sticky flags.
module sipmroc_serial_rx #(
  parameter int         FRAME_BITS  = 32,
  parameter logic [3:0] HEADER      = 4'b1010,
  parameter int         MAX_CHANNEL = 16
) (
  input  logic        clk_200m,
  input  logic        rst,
  input  logic        serial_data_en,
  input  logic        serial_data,
  input  logic        frame_ready,
  input  logic        err_clear,
  output logic        frame_valid,
  output logic [4:0]  frame_channel,
  output logic [10:0] frame_energy,
  output logic [10:0] frame_discharge,
  output logic [15:0] good_frame_cnt,
  output logic [15:0] err_cnt,
  output logic [4:0]  err_flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // A count of FRAME_BITS means a complete frame.
  // FRAME_BITS+1 marks a frame that ran too long.
  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_OVER = 6'(FRAME_BITS + 1);
  localparam logic [4:0] MAX_CH   = 5'(MAX_CHANNEL);

  state_t                state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [5:0]            bit_cnt_reg, bit_cnt_next;

  logic        valid_reg, valid_next;
  logic [4:0]  channel_reg;
  logic [10:0] energy_reg;
  logic [10:0] discharge_reg;
  logic [15:0] good_cnt_reg;
  logic [15:0] err_cnt_reg;
  logic [4:0]  err_flags_reg, err_flags_next;

  logic       in_check;
  logic       len_err, hdr_err, par_err, ch_err;
  logic       frame_ok, transfer, load, overflow;
  logic [4:0] new_err;

  // Frame assembly FSM: next state, shift register and bit counter.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE, CHECK: begin
        if (serial_data_en) begin
          // The first bit of a new frame can arrive on the same edge as CHECK.
          shift_next   = {shift_reg[FRAME_BITS-2:0], serial_data};
          bit_cnt_next = 6'd1;
          state_next   = SHIFT;
        end else begin
          state_next   = IDLE;
        end
      end
      SHIFT: begin
        if (serial_data_en) begin
          if (bit_cnt_reg < CNT_FULL) begin
            shift_next   = {shift_reg[FRAME_BITS-2:0], serial_data};
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end else begin
            // Too long: keep the counter parked at the overflow marker.
            bit_cnt_next = CNT_OVER;
          end
        end else begin
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame checks evaluated on the frozen shift register while in CHECK.
  always_comb begin
    in_check = (state_reg == CHECK);
    len_err  = in_check && (bit_cnt_reg != CNT_FULL);
    hdr_err  = in_check && !len_err && (shift_reg[31:28] != HEADER);
    par_err  = in_check && !len_err && (^shift_reg);
    ch_err   = in_check && !len_err && (shift_reg[27:23] > MAX_CH);
    frame_ok = in_check && !(len_err || hdr_err || par_err || ch_err);
    transfer = valid_reg && frame_ready;
    load     = frame_ok && (!valid_reg || frame_ready);
    overflow = frame_ok && !load;
    new_err  = {overflow, len_err, ch_err, par_err, hdr_err};
    if (load) begin
      valid_next = 1'b1;
    end else if (transfer) begin
      valid_next = 1'b0;
    end else begin
      valid_next = valid_reg;
    end
  end

  // Sticky flags: a new error bit beats a clear arriving on the same edge.
  for (genvar gi = 0; gi < 5; gi++) begin : g_err_flag
    assign err_flags_next[gi] = new_err[gi] | (err_flags_reg[gi] & ~err_clear);
  end

  // FSM, shift register and bit counter registers.
  always_ff @(posedge clk_200m) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Output holding register, saturating counters and error flags.
  always_ff @(posedge clk_200m) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      channel_reg   <= '0;
      energy_reg    <= '0;
      discharge_reg <= '0;
      good_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
      err_flags_reg <= '0;
    end else begin
      valid_reg     <= valid_next;
      err_flags_reg <= err_flags_next;
      if (load) begin
        channel_reg   <= shift_reg[27:23];
        energy_reg    <= shift_reg[22:12];
        discharge_reg <= shift_reg[11:1];
        if (good_cnt_reg != 16'hFFFF) begin
          good_cnt_reg <= good_cnt_reg + 16'd1;
        end
      end
      if ((new_err != 5'd0) && (err_cnt_reg != 16'hFFFF)) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_valid     = valid_reg;
  assign frame_channel   = channel_reg;
  assign frame_energy    = energy_reg;
  assign frame_discharge = discharge_reg;
  assign good_frame_cnt  = good_cnt_reg;
  assign err_cnt         = err_cnt_reg;
  assign err_flags       = err_flags_reg;

endmodule

// File: tb/tb_sipmroc_serial_rx.sv
`timescale 1ns/1ps
// Bench for sipmroc_serial_rx: directed scenarios plus random bursts.
// A burst-level reference model predicts every output cycle by cycle.
module tb_sipmroc_serial_rx;

  logic        clk_200m = 1'b0;
  logic        rst = 1'b1;
  logic        serial_data_en = 1'b0;
  logic        serial_data = 1'b0;
  logic        frame_ready = 1'b1;
  logic        err_clear = 1'b0;
  logic        frame_valid;
  logic [4:0]  frame_channel;
  logic [10:0] frame_energy;
  logic [10:0] frame_discharge;
  logic [15:0] good_frame_cnt;
  logic [15:0] err_cnt;
  logic [4:0]  err_flags;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;

  sipmroc_serial_rx dut (
    .clk_200m       (clk_200m),
    .rst            (rst),
    .serial_data_en (serial_data_en),
    .serial_data    (serial_data),
    .frame_ready    (frame_ready),
    .err_clear      (err_clear),
    .frame_valid    (frame_valid),
    .frame_channel  (frame_channel),
    .frame_energy   (frame_energy),
    .frame_discharge(frame_discharge),
    .good_frame_cnt (good_frame_cnt),
    .err_cnt        (err_cnt),
    .err_flags      (err_flags)
  );

  always #2.5 clk_200m = ~clk_200m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (burst level).
  bit          cur_q[$];
  bit          pend_q[$];
  bit          pend = 1'b0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_ch = '0;
  logic [10:0] m_e = '0;
  logic [10:0] m_d = '0;
  logic [15:0] m_good = '0;
  logic [15:0] m_err = '0;
  logic [4:0]  m_flags = '0;
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];

  // Model: a burst is the run of enable-high bits; it is judged two edges after its last bit.
  always @(posedge clk_200m) begin
    logic [4:0]  nf;
    logic [31:0] w;
    bit          ld;
    bit          xfer;
    if (rst) begin
      m_valid = 0; m_ch = 0; m_e = 0; m_d = 0;
      m_good = 0; m_err = 0; m_flags = 0;
      cur_q.delete(); pend_q.delete(); pend = 0;
    end else begin
      nf = 0; ld = 0; w = 0;
      xfer = m_valid && frame_ready;
      if (pend) begin
        if (pend_q.size() != 32) begin
          nf[3] = 1;
        end else begin
          foreach (pend_q[i]) w = {w[30:0], pend_q[i]};
          if (w[31:28] != 4'b1010) nf[0] = 1;
          if (($countones(w) % 2) != 0) nf[1] = 1;
          if (w[27:23] > 5'd16) nf[2] = 1;
          if (nf == 0) begin
            if (!m_valid || frame_ready) ld = 1;
            else nf[4] = 1;
          end
        end
        pend = 0;
      end
      if (xfer) exp_q.push_back({m_ch, m_e, m_d});
      if (ld) begin
        m_ch = w[27:23]; m_e = w[22:12]; m_d = w[11:1];
        m_valid = 1;
        if (m_good != 16'hFFFF) m_good = m_good + 1;
      end else if (xfer) begin
        m_valid = 0;
      end
      if (nf != 0 && m_err != 16'hFFFF) m_err = m_err + 1;
      m_flags = (err_clear ? 5'd0 : m_flags) | nf;
      if (serial_data_en) begin
        cur_q.push_back(serial_data);
      end else if (cur_q.size() > 0) begin
        pend_q = cur_q;
        cur_q.delete();
        pend = 1;
      end
    end
  end

  // Monitor: log every handshake transfer seen on the DUT outputs.
  always @(posedge clk_200m) begin
    if (!rst && frame_valid && frame_ready) begin
      obs_q.push_back({frame_channel, frame_energy, frame_discharge});
      $display("xfer ch=%0d energy=%0d discharge=%0d good=%0d err=%0d",
               frame_channel, frame_energy, frame_discharge, good_frame_cnt, err_cnt);
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk_200m) begin
    if (chk_en) begin
      check("valid", frame_valid, m_valid);
      check("channel", frame_channel, m_ch);
      check("energy", frame_energy, m_e);
      check("discharge", frame_discharge, m_d);
      check("good_cnt", good_frame_cnt, m_good);
      check("err_cnt", err_cnt, m_err);
      check("err_flags", err_flags, m_flags);
    end
  end

  function automatic logic [31:0] make_frame(input logic [3:0] hdr, input logic [4:0] ch,
                                             input logic [10:0] e, input logic [10:0] d);
    logic [31:0] w;
    w = {hdr, ch, e, d, 1'b0};
    w[0] = ^w;
    return w;
  endfunction

  task automatic drive(input logic en_v, input logic bit_v);
    @(negedge clk_200m);
    serial_data_en = en_v;
    serial_data = bit_v;
    if (rand_mode) begin
      frame_ready = ($urandom_range(0, 3) != 0);
      err_clear = ($urandom_range(0, 24) == 0);
    end
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, d[i]);
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits({32'b0, w}, 32);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk_200m);
    rst = 1; serial_data_en = 0; serial_data = 0;
    @(negedge clk_200m);
    rst = 0;
  endtask

  initial begin
    logic [31:0] good_w;
    logic [31:0] w;
    int n0;
    good_w = 32'hA1828078;
    repeat (3) @(negedge clk_200m);
    rst = 0;
    chk_en = 1;

    // Reset state
    check("rst_valid", frame_valid, 0);
    check("rst_good", good_frame_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_flags", err_flags, 0);

    // Good frame, valid exactly two edges after the last bit
    frame_ready = 1;
    send_frame(good_w);
    idle(2);
    check("good_not_early", frame_valid, 0);
    idle(1);
    check("good_valid", frame_valid, 1);
    check("good_ch", frame_channel, 3);
    check("good_energy", frame_energy, 40);
    check("good_dis", frame_discharge, 60);
    check("good_cnt1", good_frame_cnt, 1);
    check("good_flags", err_flags, 0);
    idle(2);

    // Parity error
    apply_reset();
    send_frame(good_w ^ 32'd1);
    idle(3);
    check("par_flags", err_flags, 5'b00010);
    check("par_errcnt", err_cnt, 1);
    check("par_valid", frame_valid, 0);

    // Channel 17
    apply_reset();
    send_frame(make_frame(4'b1010, 5'd17, 11'd5, 11'd6));
    idle(3);
    check("ch_flag", err_flags[2], 1);

    // Header 1011
    apply_reset();
    send_frame(make_frame(4'b1011, 5'd2, 11'd5, 11'd6));
    idle(3);
    check("hdr_flag", err_flags[0], 1);

    // Length: 31 bits, then 40 bits, then a good frame after a 1-cycle gap
    apply_reset();
    send_bits({33'b0, good_w[31:1]}, 31);
    idle(1);
    send_bits({24'b0, good_w, 8'h5A}, 40);
    idle(3);
    check("len_flags", err_flags, 5'b01000);
    check("len_errcnt", err_cnt, 2);
    check("len_valid", frame_valid, 0);
    check("len_good", good_frame_cnt, 0);
    send_frame(good_w);
    idle(1);
    send_bits({24'b0, good_w, 8'hC3}, 40);
    idle(1);
    send_frame(good_w);
    idle(3);
    check("len_after_errcnt", err_cnt, 3);
    check("len_after_good", good_frame_cnt, 2);

    // Backpressure: ch1 held, ch2 dropped, ch5 loads as ch1 transfers
    apply_reset();
    frame_ready = 0;
    send_frame(make_frame(4'b1010, 5'd1, 11'd100, 11'd200));
    idle(1);
    send_frame(make_frame(4'b1010, 5'd2, 11'd101, 11'd201));
    idle(3);
    check("bp_valid", frame_valid, 1);
    check("bp_ch", frame_channel, 1);
    check("bp_energy", frame_energy, 100);
    check("bp_ovf", err_flags[4], 1);
    check("bp_errcnt", err_cnt, 1);
    n0 = obs_q.size();
    send_frame(make_frame(4'b1010, 5'd5, 11'd300, 11'd400));
    idle(2);
    frame_ready = 1;
    idle(1);
    check("bp_ch5", frame_channel, 5);
    check("bp_valid5", frame_valid, 1);
    check("bp_errcnt2", err_cnt, 1);
    check("bp_good", good_frame_cnt, 2);
    check("bp_xfer_n", obs_q.size() - n0, 1);
    if (obs_q.size() > n0) check("bp_xfer_ch", obs_q[n0][26:22], 1);
    idle(2);

    // Stream all 17 channels back-to-back
    apply_reset();
    n0 = obs_q.size();
    for (int c = 0; c <= 16; c++) begin
      send_frame(make_frame(4'b1010, 5'(c), 11'($urandom), 11'($urandom)));
      idle(1);
    end
    idle(3);
    check("stream_good", good_frame_cnt, 17);
    check("stream_n", obs_q.size() - n0, 17);
    for (int c = 0; c <= 16; c++)
      if (n0 + c < obs_q.size()) check("stream_ch", obs_q[n0 + c][26:22], c);

    // Reset in the middle of a frame
    apply_reset();
    frame_ready = 0;
    send_frame(good_w);
    idle(3);
    w = make_frame(4'b1010, 5'd7, 11'd77, 11'd88);
    send_bits({32'b0, w} >> 18, 14);
    @(negedge clk_200m);
    rst = 1; serial_data_en = 1; serial_data = w[17];
    @(negedge clk_200m);
    rst = 0; serial_data_en = 0;
    check("mid_rst_valid", frame_valid, 0);
    check("mid_rst_ch", frame_channel, 0);
    check("mid_rst_good", good_frame_cnt, 0);
    idle(2);
    frame_ready = 1;
    send_frame(w);
    idle(3);
    check("mid_rst_ch7", frame_channel, 7);
    check("mid_rst_good1", good_frame_cnt, 1);
    check("mid_rst_err", err_cnt, 0);

    // Random bursts with random backpressure and clears
    rand_mode = 1;
    for (int k = 0; k < 250; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      w = make_frame(4'b1010, 5'($urandom_range(0, 16)), 11'($urandom), 11'($urandom));
      case (kind)
        6: w = make_frame(4'b1010, 5'($urandom_range(17, 31)), 11'($urandom), 11'($urandom));
        7: w = make_frame(4'($urandom_range(0, 9)), 5'($urandom_range(0, 16)), 11'($urandom), 11'($urandom));
        8: w = w ^ (32'd1 << $urandom_range(0, 31));
        default: ;
      endcase
      if (kind == 9) begin
        int n;
        n = $urandom_range(1, 40);
        if (n == 32) n = 33;
        send_bits({$urandom, w}, n);
      end else begin
        send_frame(w);
      end
      idle($urandom_range(1, 3));
    end
    rand_mode = 0;
    frame_ready = 1;
    err_clear = 0;
    idle(5);

    check("xfer_total", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("xfer_data", obs_q[i], exp_q[i]);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
